// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions: S-box tables, byte type, state encoding.
package aes_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned BYTES   = 16;

   // Entry i holds S(i); the byte value is the table index directly.
   localparam logic [0:255][7:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Byte k of a state sits at bits [8k:8k+7], byte 0 leftmost.
   function automatic byte_t get_byte(input logic [0:127] state, input int unsigned k);
      logic [6:0] base;
      base = 7'(k * 8);
      return state[base +: 8];
   endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lookup with operand isolation and forward/inverse select.
module aes_sbox_lane
   import aes_pkg::*;
#(
   parameter bit INVERSE_EN = 1'b1
) (
   input  logic  lane_en,
   input  logic  inv,
   input  byte_t din,
   output byte_t dout_c
);

   byte_t din_iso;
   byte_t fwd_c;

   // Idle lanes see a constant zero so the table logic does not toggle.
   assign din_iso = din & {8{lane_en}};
   assign fwd_c   = SBOX_FWD[din_iso];

   if (INVERSE_EN) begin : g_inv
      byte_t inv_c;
      assign inv_c  = SBOX_INV[din_iso];
      assign dout_c = inv ? inv_c : fwd_c;
   end else begin : g_fwd
      logic unused_inv;
      assign unused_inv = inv;
      assign dout_c     = fwd_c;
   end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes over a 128-bit state, LANES bytes per enabled cycle.
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int unsigned LANES      = 4,
   parameter bit          INVERSE_EN = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode,
   input  logic [0:127] block_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] block_out,
   output logic         busy
);

   localparam int unsigned BEATS = BYTES / LANES;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [0:127]    work_q, work_d, work_sub;
   logic            mode_q, mode_d;
   logic            work_we;
   logic            out_we;
   logic            out_valid_d;
   logic            lane_en_c;
   logic [6:0]      off;

   byte_t lane_din  [LANES];
   byte_t lane_dout [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_din[l] = get_byte(work_q, 32'(cnt_q) * LANES + 32'(l));

      aes_sbox_lane #(
         .INVERSE_EN (INVERSE_EN)
      ) u_lane (
         .lane_en (lane_en_c),
         .inv     (mode_q),
         .din     (lane_din[l]),
         .dout_c  (lane_dout[l])
      );
   end

   // Splice this beat's substituted bytes back into the working state.
   always_comb begin
      work_sub = work_q;
      off      = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         off = 7'((32'(cnt_q) * LANES + 32'(l)) * 8);
         work_sub[off +: 8] = lane_dout[l];
      end
   end

   // Next-state and datapath control; nothing advances while enable is low.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      mode_d      = mode_q;
      work_we     = 1'b0;
      out_we      = 1'b0;
      out_valid_d = out_valid;
      in_ready    = 1'b0;
      lane_en_c   = 1'b0;
      if (enable) begin
         case (state_q)
            IDLE: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  work_we = 1'b1;
                  work_d  = block_in;
                  mode_d  = mode;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               lane_en_c = 1'b1;
               work_we   = 1'b1;
               work_d    = work_sub;
               if (cnt_q == LAST) begin
                  out_we      = 1'b1;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy = (state_q == RUN) || (state_q == DONE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         out_valid <= out_valid_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         work_q <= '0;
         mode_q <= 1'b0;
      end else if (work_we) begin
         work_q <= work_d;
         mode_q <= mode_d;
      end
   end

   // Result register loads only on the RUN to DONE transition.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         block_out <= '0;
      end else if (out_we) begin
         block_out <= work_sub;
      end
   end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter across several LANES/INVERSE_EN builds.
module tb_sub_bytes_iter;

   localparam int NI = 4;

   localparam logic [0:127] FIPS_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [0:127] FIPS_OUT   = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [0:127] ALL_FF     = {16{8'hff}};
   localparam logic [0:127] ALL_16     = {16{8'h16}};
   localparam logic [0:127] ALL_00     = {16{8'h00}};
   localparam logic [0:127] ALL_63     = {16{8'h63}};
   localparam logic [0:127] INV_SB_IN  = {8'h63, 8'h60, {14{8'h00}}};
   localparam logic [0:127] INV_SB_OUT = {8'h00, 8'h90, {14{8'h52}}};
   localparam logic [0:127] FWD_SB_IN  = {8'h90, 8'h53, {14{8'hff}}};
   localparam logic [0:127] FWD_SB_OUT = {8'h60, 8'hed, {14{8'h16}}};

   typedef struct {
      int           inst;
      logic [0:127] data;
      int           due;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   last_acc = 0;
   exp_t sb_q[$];

   logic         enable    [NI];
   logic         in_valid  [NI];
   logic         in_ready  [NI];
   logic         mode      [NI];
   logic [0:127] block_in  [NI];
   logic         out_valid [NI];
   logic         out_ready [NI];
   logic [0:127] block_out [NI];
   logic         busy      [NI];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   sub_bytes_iter #(.LANES(4), .INVERSE_EN(1'b1)) u_l4 (
      .clock(clock), .reset(reset), .enable(enable[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .mode(mode[0]), .block_in(block_in[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .block_out(block_out[0]), .busy(busy[0]));

   sub_bytes_iter #(.LANES(1), .INVERSE_EN(1'b1)) u_l1 (
      .clock(clock), .reset(reset), .enable(enable[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .mode(mode[1]), .block_in(block_in[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .block_out(block_out[1]), .busy(busy[1]));

   sub_bytes_iter #(.LANES(16), .INVERSE_EN(1'b0)) u_l16 (
      .clock(clock), .reset(reset), .enable(enable[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .mode(mode[2]), .block_in(block_in[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .block_out(block_out[2]), .busy(busy[2]));

   sub_bytes_iter #(.LANES(2), .INVERSE_EN(1'b1)) u_l2 (
      .clock(clock), .reset(reset), .enable(enable[3]), .in_valid(in_valid[3]),
      .in_ready(in_ready[3]), .mode(mode[3]), .block_in(block_in[3]), .out_valid(out_valid[3]),
      .out_ready(out_ready[3]), .block_out(block_out[3]), .busy(busy[3]));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // Offer a block, wait for acceptance, and queue the expected result and due cycle.
   task automatic send(input int g, input logic [0:127] d, input logic m,
                       input logic [0:127] want, input int lat);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clock);
      in_valid[g] = 1'b1;
      block_in[g] = d;
      mode[g]     = m;
      while (!in_ready[g] && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) begin
         chk($sformatf("accept_timeout_inst%0d", g), 128'(in_ready[g]), 128'd1);
      end
      @(posedge clock);
      #1;
      last_acc = cyc;
      e.inst = g;
      e.data = want;
      e.due  = cyc + lat;
      sb_q.push_back(e);
      in_valid[g] = 1'b0;
   endtask

   task automatic wait_valid(input int g);
      int n;
      n = 0;
      @(negedge clock);
      while (!out_valid[g] && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (n >= 100) chk($sformatf("valid_timeout_inst%0d", g), 128'(out_valid[g]), 128'd1);
   endtask

   task automatic wait_done(input int g);
      wait_valid(g);
      @(negedge clock);
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_mon
      logic ov_prev = 1'b0;
      always @(negedge clock) begin
         exp_t e;
         if (out_valid[g] && !ov_prev) begin
            if (sb_q.size() == 0 || sb_q[0].inst != g) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output inst %0d: got %h expected nothing", g, block_out[g]);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("data_inst%0d", g), 128'(block_out[g]), 128'(e.data));
               chk($sformatf("latency_inst%0d", g), 128'(cyc), 128'(e.due));
            end
         end
         ov_prev <= out_valid[g];
      end
   end

   initial begin
      for (int g = 0; g < NI; g++) begin
         enable[g]    = 1'b1;
         in_valid[g]  = 1'b0;
         mode[g]      = 1'b0;
         out_ready[g] = 1'b1;
         block_in[g]  = '0;
      end
      #2 reset = 1'b1;
      #1;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("rst_out_valid_%0d", g), 128'(out_valid[g]), 128'd0);
         chk($sformatf("rst_block_out_%0d", g), 128'(block_out[g]), 128'd0);
         chk($sformatf("rst_in_ready_%0d", g), 128'(in_ready[g]), 128'd1);
         chk($sformatf("rst_busy_%0d", g), 128'(busy[g]), 128'd0);
      end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Idle lanes stay isolated even with a live block_in.
      block_in[0] = FIPS_IN;
      #1;
      chk("iso_idle_lane0", 128'(u_l4.g_lane[0].u_lane.din_iso), 128'd0);
      chk("iso_idle_lane3", 128'(u_l4.g_lane[3].u_lane.din_iso), 128'd0);

      // Forward/inverse vectors, LANES=4.
      send(0, FIPS_IN, 1'b0, FIPS_OUT, 4);   wait_done(0);
      chk("hold_after_consume", 128'(block_out[0]), 128'(FIPS_OUT));
      send(0, FIPS_OUT, 1'b1, FIPS_IN, 4);   wait_done(0);
      send(0, INV_SB_IN, 1'b1, INV_SB_OUT, 4); wait_done(0);
      send(0, FWD_SB_IN, 1'b0, FWD_SB_OUT, 4); wait_done(0);

      // LANES=1 and LANES=16, the latter built forward-only.
      send(1, FIPS_IN, 1'b0, FIPS_OUT, 16);  wait_done(1);
      send(2, FIPS_IN, 1'b0, FIPS_OUT, 1);   wait_done(2);
      send(2, FIPS_IN, 1'b1, FIPS_OUT, 1);   wait_done(2);

      // Backpressure with a competing block held on the input.
      out_ready[0] = 1'b0;
      send(0, ALL_FF, 1'b0, ALL_16, 4);
      wait_valid(0);
      in_valid[0] = 1'b1;
      block_in[0] = FIPS_IN;
      mode[0]     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_block_out", 128'(block_out[0]), 128'(ALL_16));
         chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
         chk("bp_busy", 128'(busy[0]), 128'd1);
      end
      out_ready[0] = 1'b1;
      @(posedge clock);
      #1;
      begin
         int hs;
         hs = cyc;
         send(0, FIPS_IN, 1'b0, FIPS_OUT, 4);
         chk("accept_after_handshake", 128'(last_acc), 128'(hs + 1));
      end
      wait_done(0);

      // Clock-enable gating during RUN, then during DONE, LANES=2.
      send(3, FIPS_IN, 1'b0, FIPS_OUT, 8 + 3);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      enable[3] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("gate_iso_lane0", 128'(u_l2.g_lane[0].u_lane.din_iso), 128'd0);
         chk("gate_iso_lane1", 128'(u_l2.g_lane[1].u_lane.din_iso), 128'd0);
         chk("gate_in_ready", 128'(in_ready[3]), 128'd0);
         @(negedge clock);
      end
      enable[3] = 1'b1;
      out_ready[3] = 1'b0;
      wait_valid(3);
      enable[3]    = 1'b0;
      out_ready[3] = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("gate_done_held", 128'(out_valid[3]), 128'd1);
      enable[3] = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("gate_done_consumed", 128'(out_valid[3]), 128'd0);
      send(3, FIPS_OUT, 1'b1, FIPS_IN, 8); wait_done(3);

      // Asynchronous reset in the middle of RUN.
      send(0, FIPS_IN, 1'b0, FIPS_OUT, 4);
      @(posedge clock);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("midrun_out_valid", 128'(out_valid[0]), 128'd0);
      chk("midrun_block_out", 128'(block_out[0]), 128'd0);
      chk("midrun_in_ready", 128'(in_ready[0]), 128'd1);
      chk("midrun_busy", 128'(busy[0]), 128'd0);
      void'(sb_q.pop_back());
      @(negedge clock);
      reset = 1'b0;
      send(0, ALL_00, 1'b0, ALL_63, 4);  wait_done(0);

      repeat (5) @(negedge clock);
      chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Parametrised, iterative successor to the single-cycle SubBytes stage; it applies the AES S-box, forward or inverse, to a 128-bit state.
- Processes LANES bytes per cycle, so area and latency trade off through a parameter.
- Uses a valid/ready handshake on both sides, plus enable-based clock-gating/operand isolation for low power.
- Sits between AddRoundKey and ShiftRows in the round datapath, and in the key-schedule SubWord path (LANES=4).

Parameters:
- LANES, 4, S-box lookups per cycle. Legal values are 1, 2, 4, 8, 16; any other value fails elaboration. BEATS = 16/LANES.
- INVERSE_EN, 1, when 1 the inverse S-box is built and mode is honoured; when 0, mode is ignored and forward only.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global activity gate. When low, all state freezes and S-box inputs are isolated.
- in_valid  in  1  block_in/mode are valid.
- in_ready  out  1  block accepted on a cycle where in_valid && in_ready.
- mode  in  1  0 = SubBytes, 1 = InvSubBytes. Sampled at accept.
- block_in  in  [0:127]  input state; byte k = bits [8k:8k+7], byte 0 at bits [0:7].
- out_valid  out  1  block_out holds a completed result.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- block_out  out  [0:127]  result, same byte ordering as block_in.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, beat counter=0, work register=0, block_out=0, out_valid=0, in_ready reflects IDLE&&enable.
- States:
  - IDLE: in_ready = enable. On accept, load work register from block_in, latch mode, counter=0, go to RUN.
  - RUN: each enabled cycle, bytes [counter*LANES .. counter*LANES+LANES-1] of the work register are replaced by their S-box value (inverse if the latched mode=1 and INVERSE_EN=1).
    - When counter = BEATS-1, the final substituted value is written into block_out, out_valid is set, and the state goes to DONE.
    - Otherwise counter increments.
  - DONE: out_valid=1, block_out stable. On out_valid && out_ready, clear out_valid and go to IDLE. in_ready=0 in DONE, so there is no accept/complete overlap.
- Latency: out_valid rises BEATS rising edges after the accept edge when enable stays high (LANES=16: 1 cycle; LANES=1: 16 cycles). Throughput is one block per BEATS+2 cycles.
- enable low:
  - State, counter, work register, block_out and out_valid are held.
  - in_ready=0.
  - The out_ready handshake is ignored, so the result is not consumed while enable=0.
  - S-box lane inputs are forced to 8'h00 (operand isolation).
  - Latency extends by exactly the number of enable-low cycles; the result is unchanged.
- Operand isolation: lane inputs are forced to 0 whenever state != RUN. The work register and block_out use load-enable structure suitable for clock-gate inference.
- Counter width: $clog2(BEATS), minimum 1 bit. For LANES=16 the counter stays 0 and RUN lasts one cycle. There is no wrap-around beyond BEATS-1.
- block_out changes only on the RUN→DONE transition and at reset; between blocks it holds the last result.
- Lookup indexing: the S-box index is the full 8-bit byte value directly (row nibble = bits 0:3, column nibble = bits 4:7); no arithmetic index formation.

Decomposition:
- Package aes_pkg:
  - SBOX_FWD and SBOX_INV 256×8 constant tables.
  - byte_t typedef.
  - Function get_byte(state, k).
  - State encoding localparams (IDLE, RUN, DONE).
- Sub-module aes_sbox_lane:
  - Combinational, one byte in, one byte out, input isolation AND with lane-enable, mode select.
  - Generated LANES times; the inverse table is omitted when INVERSE_EN=0.

Test Plan:
1. Reset asserted mid-RUN (LANES=4, after beat 2) → out_valid=0, block_out=0, in_ready=1 immediately (asynchronous). A subsequent accept of block 00..00 yields all bytes 0x63.
2. LANES=4, mode=0, block_in=193de3bea0f4e22b9ac68d2ae9f84808 (FIPS-197 App. B) → block_out=d42711aee0bf98f1b8b45de51e415230, out_valid exactly 4 cycles after accept; repeat for LANES=1 (16 cycles) and LANES=16 (1 cycle).
3. Inverse round trip, mode=1, block_in=d42711aee0bf98f1b8b45de51e415230 → 193de3bea0f4e22b9ac68d2ae9f84808. Single-byte checks: Inv(0x63)=0x00, Inv(0x60)=0x90. With INVERSE_EN=0, mode=1 gives the forward result.
4. Backpressure: out_ready held low 5 cycles after out_valid → block_out stable, in_ready=0, busy=1. in_valid held high with a new block is not accepted until the cycle after the out handshake.
5. enable dropped for 3 cycles during RUN (LANES=2) → out_valid at 8+3 cycles after accept, correct result. S-box lane inputs observed as 0x00 during gating and in IDLE.
6. All-0xFF block, forward → all bytes 0x16. Byte 0x90 at byte 0 → 0x60, and byte 0x53 → 0xED, checking both nibble orderings.
